// File: rtl/dvp_frame_capture_if.sv
// Frame request handshake and synchronous frame-RAM read port between the
// camera AHB slave (master side) and the DVP capture block (slave side).
interface dvp_frame_capture_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [31:0]           RDATA;

    modport master (
        output DATA_VALID,
        output ADDR,
        input  DATA_READY,
        input  RDATA
    );

    modport slave (
        input  DATA_VALID,
        input  ADDR,
        output DATA_READY,
        output RDATA
    );
endinterface

// File: rtl/dvp_frame_capture.sv
// Captures one DVP camera frame per request into an internal word RAM,
// packing bytes little-endian, with a registered read port for AHB reads.
module dvp_frame_capture #(
    parameter int FRAME_WORDS = 9600,
    parameter int ADDR_WIDTH  = 16,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    dvp_frame_capture_if.slave  bus,
    input  logic                CAM_PCLK,
    input  logic                CAM_VSYNC,
    input  logic                CAM_HREF,
    input  logic [7:0]          CAM_DATA,
    output logic                FRAME_ERR,
    output logic                BUSY
);

    // One extra count bit lets a long frame count past FRAME_WORDS without wrapping
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_WAIT_FRAME,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic             frame_err, err_n;
    logic [1:0]       byte_idx, byte_idx_n;
    logic [CNT_W-1:0] waddr, waddr_n;
    logic [31:0]      word_buf, word_n;
    logic             we;
    logic [31:0]      wdata;

    logic             pclk_p0, pclk_p1, pclk_p2;
    logic             vsync_p0, vsync_p1;
    logic             href_p0, href_p1;
    logic [7:0]       data_p0, data_p1;
    logic             pclk_rise, vs;

    logic [31:0]      mem [2**ADDR_WIDTH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced PCLK
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pclk_p0  <= 1'b0;
            pclk_p1  <= 1'b0;
            pclk_p2  <= 1'b0;
            vsync_p0 <= 1'b0;
            vsync_p1 <= 1'b0;
            href_p0  <= 1'b0;
            href_p1  <= 1'b0;
        end else begin
            pclk_p0  <= CAM_PCLK;
            pclk_p1  <= pclk_p0;
            pclk_p2  <= pclk_p1;
            vsync_p0 <= CAM_VSYNC;
            vsync_p1 <= vsync_p0;
            href_p0  <= CAM_HREF;
            href_p1  <= href_p0;
        end
    end

    always_ff @(posedge HCLK) begin
        data_p0 <= CAM_DATA;
        data_p1 <= data_p0;
    end

    assign pclk_rise = pclk_p1 & ~pclk_p2;
    assign vs        = ~(vsync_p1 ^ VSYNC_POL);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            frame_err <= 1'b0;
            byte_idx  <= 2'd0;
            waddr     <= '0;
        end else begin
            state     <= state_n;
            frame_err <= err_n;
            byte_idx  <= byte_idx_n;
            waddr     <= waddr_n;
        end
    end

    always_ff @(posedge HCLK) begin
        word_buf <= word_n;
    end

    always_comb begin
        state_n    = state;
        err_n      = frame_err;
        byte_idx_n = byte_idx;
        waddr_n    = waddr;
        word_n     = word_buf;
        we         = 1'b0;
        wdata      = word_buf;
        case (state)
            S_IDLE: begin
                if (bus.DATA_VALID) begin
                    state_n = S_WAIT_VS;
                    err_n   = 1'b0;
                end
            end
            S_WAIT_VS: begin
                if (vs) state_n = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (!vs) begin
                    state_n    = S_CAPTURE;
                    waddr_n    = '0;
                    byte_idx_n = 2'd0;
                end
            end
            S_CAPTURE: begin
                if (vs) begin
                    state_n = S_FLUSH;
                end else if (pclk_rise && href_p1) begin
                    // A fresh word starts zeroed so a final partial word is padded
                    word_n = (byte_idx == 2'd0) ? 32'h0 : word_buf;
                    word_n[{byte_idx, 3'b000} +: 8] = data_p1;
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        we      = (waddr < FRAME_CNT);
                        wdata   = word_n;
                        waddr_n = sat_inc(waddr);
                    end
                end
            end
            S_FLUSH: begin
                if (byte_idx != 2'd0) begin
                    we      = (waddr < FRAME_CNT);
                    wdata   = word_buf;
                    waddr_n = sat_inc(waddr);
                end
                // A frame is good only if it filled exactly FRAME_WORDS whole words
                err_n   = (byte_idx != 2'd0) || (waddr != FRAME_CNT);
                state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.DATA_READY = (state == S_DONE);
    assign BUSY           = (state != S_IDLE);
    assign FRAME_ERR      = frame_err;

    always_ff @(posedge HCLK) begin
        if (we) mem[waddr[ADDR_WIDTH-1:0]] <= wdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) bus.RDATA <= 32'h0;
        else          bus.RDATA <= mem[bus.ADDR];
    end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Directed bench for dvp_frame_capture with an 8-word frame and a 3-bit RAM address.
module tb_dvp_frame_capture;

    logic       HCLK;
    logic       HRESETn;
    logic       CAM_PCLK;
    logic       CAM_VSYNC;
    logic       CAM_HREF;
    logic [7:0] CAM_DATA;
    logic       FRAME_ERR;
    logic       BUSY;

    int n_total = 0;
    int n_bad   = 0;
    int ready_cnt = 0;
    int ready_base;

    dvp_frame_capture_if #(.ADDR_WIDTH(3)) bus ();

    dvp_frame_capture #(
        .FRAME_WORDS (8),
        .ADDR_WIDTH  (3),
        .VSYNC_POL   (1'b1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .CAM_PCLK  (CAM_PCLK),
        .CAM_VSYNC (CAM_VSYNC),
        .CAM_HREF  (CAM_HREF),
        .CAM_DATA  (CAM_DATA),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (bus.DATA_READY === 1'b1) ready_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One PCLK period = 8 HCLK: low for 4, high for 4
    task automatic cam_byte(input logic [7:0] d, input logic href);
        @(negedge HCLK);
        CAM_DATA = d;
        CAM_HREF = href;
        CAM_PCLK = 1'b0;
        repeat (4) @(negedge HCLK);
        CAM_PCLK = 1'b1;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0 && i % 16 == 0) begin
                cam_byte(8'h55, 1'b0);
                cam_byte(8'h55, 1'b0);
            end
            cam_byte(8'(base + i), 1'b1);
        end
    endtask

    task automatic vsync_pulse();
        @(negedge HCLK);
        CAM_VSYNC = 1'b1;
        for (int i = 0; i < 3; i++) cam_byte(8'h00, 1'b0);
        CAM_VSYNC = 1'b0;
        for (int i = 0; i < 2; i++) cam_byte(8'h00, 1'b0);
    endtask

    task automatic frame_end(input string tag);
        logic got;
        got = 1'b0;
        @(negedge HCLK);
        CAM_VSYNC = 1'b1;
        CAM_HREF  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (bus.DATA_READY === 1'b1) begin
                bus.DATA_VALID = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check_val(tag, got, 1'b1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge HCLK);
        bus.ADDR = a;
        @(posedge HCLK);
        #1;
        check_val(tag, bus.RDATA, exp);
    endtask

    initial begin
        HRESETn        = 1'b0;
        CAM_PCLK       = 1'b0;
        CAM_VSYNC      = 1'b0;
        CAM_HREF       = 1'b0;
        CAM_DATA       = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.ADDR       = 3'd0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_val("rst_busy", BUSY, 1'b0);
        check_val("rst_ready", bus.DATA_READY, 1'b0);
        check_val("rst_err", FRAME_ERR, 1'b0);
        check_val("rst_rdata", bus.RDATA, 32'h0);

        // Frame 1 preloads RAM[0] with DEADBEEF
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        cam_byte(8'hEF, 1'b1);
        cam_byte(8'hBE, 1'b1);
        cam_byte(8'hAD, 1'b1);
        cam_byte(8'hDE, 1'b1);
        send_bytes(8'h04, 28);
        frame_end("f1_ready");
        check_val("f1_err", FRAME_ERR, 1'b0);
        rd_chk("f1_ram0", 3'd0, 32'hDEADBEEF);
        rd_chk("f1_ram1", 3'd1, 32'h07060504);

        // Frame 2: HREF gap inside word 0, read-first collision on ADDR 0
        bus.ADDR       = 3'd0;
        ready_base     = ready_cnt;
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        cam_byte(8'h00, 1'b1);
        cam_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) cam_byte(8'hAA, 1'b0);
        cam_byte(8'h02, 1'b1);
        @(negedge HCLK);
        CAM_DATA = 8'h03;
        CAM_HREF = 1'b1;
        CAM_PCLK = 1'b0;
        repeat (4) @(negedge HCLK);
        CAM_PCLK = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check_val("rf_same", bus.RDATA, 32'hDEADBEEF);
        @(posedge HCLK);
        #1;
        check_val("rf_next", bus.RDATA, 32'h03020100);
        send_bytes(8'h04, 28);
        frame_end("f2_ready");
        repeat (20) @(negedge HCLK);
        check_val("f2_pulses", ready_cnt - ready_base, 1);
        check_val("f2_idle", BUSY, 1'b0);
        check_val("f2_err", FRAME_ERR, 1'b0);
        rd_chk("f2_ram0", 3'd0, 32'h03020100);
        rd_chk("f2_ram4", 3'd4, 32'h13121110);
        rd_chk("f2_ram7", 3'd7, 32'h1F1E1D1C);

        // Request arrives mid-frame: that frame must be skipped
        @(negedge HCLK);
        CAM_VSYNC = 1'b0;
        send_bytes(8'h50, 4);
        bus.DATA_VALID = 1'b1;
        repeat (4) @(negedge HCLK);
        check_val("mid_busy", BUSY, 1'b1);
        send_bytes(8'h58, 8);
        vsync_pulse();
        send_bytes(8'h60, 32);
        frame_end("mid_ready");
        check_val("mid_err", FRAME_ERR, 1'b0);
        rd_chk("mid_ram0", 3'd0, 32'h63626160);
        rd_chk("mid_ram7", 3'd7, 32'h7F7E7D7C);

        // Short frame of 30 bytes: last word padded
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(8'h80, 30);
        frame_end("short_ready");
        check_val("short_err", FRAME_ERR, 1'b1);
        rd_chk("short_ram6", 3'd6, 32'h9B9A9998);
        rd_chk("short_ram7", 3'd7, 32'h00009D9C);

        // Long frame of 40 bytes: extra words must not wrap into low addresses
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(8'hA0, 40);
        frame_end("long_ready");
        check_val("long_err", FRAME_ERR, 1'b1);
        rd_chk("long_ram0", 3'd0, 32'hA3A2A1A0);
        rd_chk("long_ram1", 3'd1, 32'hA7A6A5A4);
        rd_chk("long_ram7", 3'd7, 32'hBFBEBDBC);

        // Asynchronous reset during capture, then a clean capture
        ready_base     = ready_cnt;
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(8'h30, 6);
        check_val("ar_busy_pre", BUSY, 1'b1);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_val("ar_busy", BUSY, 1'b0);
        check_val("ar_ready", bus.DATA_READY, 1'b0);
        check_val("ar_err", FRAME_ERR, 1'b0);
        bus.DATA_VALID = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        bus.DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(8'hD0, 32);
        frame_end("ar2_ready");
        repeat (20) @(negedge HCLK);
        check_val("ar2_pulses", ready_cnt - ready_base, 1);
        check_val("ar2_err", FRAME_ERR, 1'b0);
        rd_chk("ar2_ram0", 3'd0, 32'hD3D2D1D0);
        rd_chk("ar2_ram7", 3'd7, 32'hEFEEEDEC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dvp_frame_capture.md
Name: dvp_frame_capture

Overview:
- Producer end of the camera frame-buffer handshake used by the camera AHB slave.
- When DATA_VALID is high (a frame request), the block waits for the next frame boundary on the camera DVP bus. It then packs bytes into 32-bit words, writes them into an internal frame RAM, and pulses DATA_READY.
- The RAM is read through a synchronous port (ADDR/RDATA) that serves AHB data-phase reads.
- Camera pins are asynchronous to HCLK and are oversampled. HCLK must be at least 4× CAM_PCLK.

Parameters:
- FRAME_WORDS, 9600, number of words in one complete frame (160×120 RGB565).
- ADDR_WIDTH, 16, RAM word-address width. Must satisfy FRAME_WORDS ≤ 2^ADDR_WIDTH.
- VSYNC_POL, 1, active level of CAM_VSYNC. VSYNC is asserted between frames.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- DATA_VALID  input  1  frame request; held high until DATA_READY is seen
- DATA_READY  output  1  one-cycle pulse: capture finished
- ADDR  input  ADDR_WIDTH  RAM read word address
- RDATA  output  32  RAM read data, registered, 1-cycle latency
- CAM_PCLK  input  1  camera pixel clock (asynchronous)
- CAM_VSYNC  input  1  camera frame sync (asynchronous)
- CAM_HREF  input  1  camera line-valid (asynchronous)
- CAM_DATA  input  8  camera pixel byte (asynchronous)
- FRAME_ERR  output  1  last capture word count ≠ FRAME_WORDS
- BUSY  output  1  FSM not in IDLE

Behaviour:
- Synchronisation:
  - CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_DATA each pass through a 2-FF synchroniser, all in the same pipeline stage.
  - pclk_rise = synced PCLK high AND previous synced PCLK low.
  - vs = synced VSYNC XNOR VSYNC_POL (1 = in vertical blanking).
- Reset values: DATA_READY=0, RDATA=0, FRAME_ERR=0, BUSY=0, FSM=IDLE, word address=0, byte index=0. RAM contents are not reset.
- FSM states:
  - IDLE: if DATA_VALID=1, go to WAIT_VS and clear FRAME_ERR.
  - WAIT_VS: wait for vs=1, so a partially-started frame is never captured. Then go to WAIT_FRAME.
  - WAIT_FRAME: wait for vs=0. Then clear word address and byte index, and go to CAPTURE.
  - CAPTURE:
    - On pclk_rise with synced HREF=1, load the byte into lane [byte_idx*8+7 : byte_idx*8]. Byte 0 goes to [7:0] (little-endian).
    - When byte_idx=3, write the completed word to RAM[waddr] in the same cycle; waddr += 1; byte_idx ← 0.
    - On vs=1 (end of frame), go to FLUSH.
  - FLUSH:
    - If byte_idx≠0, write the partial word with unused upper lanes forced to 0, and advance waddr.
    - FRAME_ERR ← (final word count ≠ FRAME_WORDS).
    - Go to DONE.
  - DONE: DATA_READY=1 for exactly this cycle (Moore output). Go to IDLE. The requester drops DATA_VALID on the next cycle, so IDLE does not re-trigger.
- Overflow: once waddr = FRAME_WORDS, further RAM writes are suppressed, but counting continues so FRAME_ERR reports the long frame. Addresses never wrap.
- Short frame (VSYNC before FRAME_WORDS words): words beyond the last written address keep their old contents, and FRAME_ERR=1.
- HREF low: bytes are ignored; byte_idx is preserved across line gaps, so packing continues across lines.
- Read port:
  - RDATA ← RAM[ADDR] every cycle, in any state.
  - Read and write to the same address in the same cycle return the old data (read-first).
  - ADDR ≥ FRAME_WORDS returns an undefined value from RAM; no error is raised.
- DATA_VALID dropping mid-capture is ignored; the capture completes.
- Asynchronous reset mid-capture: immediate return to IDLE, and no DATA_READY pulse is issued.

Test Plan:
- FRAME_WORDS=8; VSYNC pulse, then 2 lines of 16 bytes 0x00..0x1F with HREF; DATA_VALID held → RAM[0]=0x03020100, RAM[7]=0x1F1E1D1C; exactly one DATA_READY pulse after VSYNC reasserts; FRAME_ERR=0.
- DATA_VALID raised while vs=0 in the middle of a frame → the mid-frame bytes are not written; capture starts only after the next vs=1→0 transition. The first word equals the first bytes of the following frame.
- Frame of 30 bytes (FRAME_WORDS=8) → RAM[7]=0x00001D1C (padded); FRAME_ERR=1. Frame of 40 bytes → RAM[8] not written; FRAME_ERR=1.
- HREF low for 3 PCLKs between bytes 1 and 2 of a word → RAM[0] still 0x03020100; no spurious writes.
- Read ADDR=0 in the cycle RAM[0] is written with 0x03020100 (old value 0xDEADBEEF) → RDATA=0xDEADBEEF; the next read returns 0x03020100.
- Assert HRESETn=0 during CAPTURE → BUSY=0 and DATA_READY=0 immediately. A new DATA_VALID after reset captures a full frame correctly.
